// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one multi-cycle main memory between the I-cache
// and D-cache miss handlers. One client owns the memory at a time. Read data
// valids are steered only to the current owner. Ownership is held until the
// owner drops its request and every outstanding read has returned.
//
// Optional feature: define ARB_RR_EN to alternate ties between the two
// clients. When it is not defined, the D-side always wins a tie.
//
// Handshake: a client raises *_req and holds it for the whole transaction.
// *_gnt is decoded from the registered state, so a request sampled at edge N
// is granted from edge N onward. The memory is driven from the cycle after
// that edge. Read returns arrive as mem_rvld pulses. These are counted against
// issued reads, and the memory latency does not matter.
module cache_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MAX_INFLIGHT = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_data_vld,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_data_vld,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvld,
    output logic [1:0]        dbg_state,
    output logic [2:0]        dbg_inflight
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_I_OWN   = 2'd1,
        S_D_OWN   = 2'd2,
        S_D_WRITE = 2'd3
    } state_e;

    localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

    state_e     state_q, state_d;
    logic [2:0] inflight_q, inflight_d;
    logic       d_wins_tie;
    logic       rd_issue;
    logic       rd_return;

`ifdef ARB_RR_EN
    // 1 means that the D-side was the most recent owner.
    logic last_owner_q, last_owner_d;
`endif

    // Tie-break choice. In the round-robin build it favours the client that
    // did not own the memory last.
    always_comb begin
        d_wins_tie = 1'b1;
`ifdef ARB_RR_EN
        d_wins_tie = ~last_owner_q;
`endif
    end

    // Next-state logic. An owner is released only when its request is low and
    // no reads are outstanding, so late data always reaches the client that
    // issued the read.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_req && d_req) begin
                    if (d_wins_tie) state_d = d_wr ? S_D_WRITE : S_D_OWN;
                    else            state_d = S_I_OWN;
                end else if (i_req) begin
                    state_d = S_I_OWN;
                end else if (d_req) begin
                    state_d = d_wr ? S_D_WRITE : S_D_OWN;
                end
            end
            S_I_OWN: begin
                if (!i_req && (inflight_q == 3'd0)) state_d = S_IDLE;
            end
            S_D_OWN: begin
                if (!d_req && (inflight_q == 3'd0)) state_d = S_IDLE;
            end
            S_D_WRITE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

`ifdef ARB_RR_EN
    // Record which client was granted when the arbiter leaves IDLE.
    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == S_IDLE && state_d != S_IDLE)
            last_owner_d = (state_d == S_D_OWN) || (state_d == S_D_WRITE);
    end
`endif

    // Outstanding-read counter. It saturates at the top and never goes below
    // zero. A return at zero is spurious and is ignored.
    always_comb begin
        rd_issue   = mem_en & ~mem_wr;
        rd_return  = mem_rvld & (inflight_q != 3'd0);
        inflight_d = inflight_q;
        if (rd_issue && !rd_return) begin
            if (inflight_q != MAX_CNT) inflight_d = inflight_q + 3'd1;
        end else if (rd_return && !rd_issue) begin
            inflight_d = inflight_q - 3'd1;
        end
    end

    // Memory-side and grant decode. These are built from the registered state
    // and the owner's live request/address. They never depend on mem_rvld.
    always_comb begin
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            S_I_OWN: begin
                i_gnt    = 1'b1;
                mem_en   = i_req;
                mem_addr = i_addr;
            end
            S_D_OWN: begin
                d_gnt    = 1'b1;
                mem_en   = d_req;
                mem_addr = d_addr;
            end
            S_D_WRITE: begin
                d_gnt     = 1'b1;
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    // Steer returning read data to the owner only. Returns in IDLE or in
    // D_WRITE are dropped.
    always_comb begin
        i_data_vld   = mem_rvld & (state_q == S_I_OWN);
        d_data_vld   = mem_rvld & (state_q == S_D_OWN);
        rdata        = mem_rdata;
        dbg_state    = state_q;
        dbg_inflight = inflight_q;
    end

    // State, counter and optional last-owner registers. Reset drops every
    // grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            inflight_q   <= 3'd0;
`ifdef ARB_RR_EN
            last_owner_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
`ifdef ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed bench for cache_mem_arbiter. It covers a
// block fill with a 4-cycle memory model, a D-side store, release with reads
// outstanding, tie-breaking, reset during a fill, and stray read returns.
module tb_cache_mem_arbiter;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_I_OWN   = 2'd1;
    localparam logic [1:0] ST_D_OWN   = 2'd2;
    localparam logic [1:0] ST_D_WRITE = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_gnt, i_data_vld;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_gnt, d_data_vld;
    logic [15:0] rdata;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_rvld = 1'b0;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_inflight;

    int checks = 0;
    int errors = 0;
    int i_pulses = 0;
    int d_pulses = 0;
    bit model_on = 1'b0;
    logic [3:0]  pv = '0;
    logic [15:0] pa [4];
    logic [15:0] exp_q [$];

    cache_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_data_vld(i_data_vld),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_data_vld(d_data_vld), .rdata(rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvld(mem_rvld),
        .dbg_state(dbg_state), .dbg_inflight(dbg_inflight)
    );

    // Clock generation: 10 ns period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock cycle. Before the edge, sample the outputs and
    // capture any read that was issued. After the edge, advance the memory
    // model, which has a 4-cycle latency. Read data is the address XOR 0xA5A5.
    task automatic cycle();
        logic        rd;
        logic [15:0] ad;
        #1;
        rd = mem_en & ~mem_wr;
        ad = mem_addr;
        if (i_data_vld) i_pulses++;
        if (d_data_vld) d_pulses++;
        if (i_data_vld && exp_q.size() > 0) check("fill_rdata", rdata, exp_q.pop_front());
        @(posedge clk);
        #1;
        if (model_on) begin
            pv    = {pv[2:0], rd};
            pa[3] = pa[2]; pa[2] = pa[1]; pa[1] = pa[0]; pa[0] = ad;
            mem_rvld  = pv[3];
            mem_rdata = pa[3] ^ 16'hA5A5;
        end
    endtask

    initial begin
        bit reached_idle;
        for (int k = 0; k < 4; k++) pa[k] = '0;

        // Reset state.
        #2;
        check("rst_i_gnt", i_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_vld", {i_data_vld, d_data_vld}, 0);
        check("rst_state", dbg_state, ST_IDLE);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // I-side block fill: 8 reads, returned through the 4-cycle model.
        model_on = 1'b1;
        i_pulses = 0; d_pulses = 0;
        i_req = 1'b1; i_addr = 16'h0000;
        #1;
        check("fill_idle_mem_en", mem_en, 0);
        check("fill_idle_gnt", i_gnt, 0);
        cycle();
        for (int k = 0; k < 8; k++) begin
            i_addr = 16'(2 * k);
            exp_q.push_back(16'(2 * k) ^ 16'hA5A5);
            #1;
            check("fill_i_gnt", i_gnt, 1);
            check("fill_mem_en", mem_en, 1);
            check("fill_mem_addr", mem_addr, 16'(2 * k));
            cycle();
        end
        i_req = 1'b0;
        reached_idle = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (dbg_state == ST_IDLE) begin
                reached_idle = 1'b1;
                break;
            end
            check("drain_i_gnt", i_gnt, 1);
            check("drain_mem_en", mem_en, 0);
            cycle();
        end
        check("fill_released", reached_idle, 1);
        check("fill_i_pulses", i_pulses, 8);
        check("fill_d_pulses", d_pulses, 0);
        check("fill_exp_q_empty", exp_q.size(), 0);
        model_on = 1'b0; mem_rvld = 1'b0; pv = '0;
        cycle();

        // D-side write-through store.
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h1234; d_wdata = 16'hBEEF;
        cycle();
        d_req = 1'b0; d_wr = 1'b0;
        #1;
        check("wr_state", dbg_state, ST_D_WRITE);
        check("wr_mem_en", mem_en, 1);
        check("wr_mem_wr", mem_wr, 1);
        check("wr_mem_addr", mem_addr, 16'h1234);
        check("wr_mem_wdata", mem_wdata, 16'hBEEF);
        check("wr_d_gnt", d_gnt, 1);
        check("wr_i_gnt", i_gnt, 0);
        cycle();
        #1;
        check("wr_back_idle", dbg_state, ST_IDLE);
        check("wr_after_mem_en", mem_en, 0);
        check("wr_after_wdata", mem_wdata, 0);
        check("wr_no_inflight", dbg_inflight, 0);

        // Release with 3 reads outstanding while the D-side is waiting.
        i_pulses = 0; d_pulses = 0;
        i_req = 1'b1; i_addr = 16'h0100;
        cycle();
        for (int k = 0; k < 3; k++) begin
            i_addr = 16'h0100 + 16'(2 * k);
            #1;
            check("out3_mem_en", mem_en, 1);
            cycle();
        end
        i_req = 1'b0; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2000;
        #1;
        check("out3_hold_gnt", i_gnt, 1);
        check("out3_inflight", dbg_inflight, 3);
        cycle();
        for (int k = 0; k < 3; k++) begin
            mem_rvld = 1'b1; mem_rdata = 16'(k);
            #1;
            check("out3_i_vld", i_data_vld, 1);
            check("out3_d_vld", d_data_vld, 0);
            check("out3_i_gnt", i_gnt, 1);
            cycle();
        end
        mem_rvld = 1'b0;
        #1;
        check("out3_last_gnt", i_gnt, 1);
        check("out3_drained", dbg_inflight, 0);
        cycle();
        #1;
        check("out3_idle_gap", dbg_state, ST_IDLE);
        check("out3_gap_d_gnt", d_gnt, 0);
        cycle();
        #1;
        check("out3_d_gnt", d_gnt, 1);
        check("out3_d_state", dbg_state, ST_D_OWN);
        check("out3_d_addr", mem_addr, 16'h2000);
        check("out3_d_en", mem_en, 1);
        cycle();
        d_req = 1'b0; mem_rvld = 1'b1;
        #1;
        check("dfill_d_vld", d_data_vld, 1);
        check("dfill_i_vld", i_data_vld, 0);
        cycle();
        mem_rvld = 1'b0;
        cycle();
        #1;
        check("dfill_released", dbg_state, ST_IDLE);
        check("out3_i_pulses", i_pulses, 3);
        check("out3_d_pulses", d_pulses, 1);

        // Two ties in a row, both using single-cycle writes on the D-side.
        i_req = 1'b1; i_addr = 16'h0040; d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0050;
        cycle();
        #1;
        check("tie1_d_write", dbg_state, ST_D_WRITE);
        cycle();
        #1;
        check("tie_idle_gap", dbg_state, ST_IDLE);
        cycle();
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        #1;
`ifdef ARB_RR_EN
        check("tie2_rr_i", dbg_state, ST_I_OWN);
        check("tie2_rr_i_gnt", i_gnt, 1);
`else
        check("tie2_fixed_d", dbg_state, ST_D_WRITE);
        check("tie2_fixed_d_gnt", d_gnt, 1);
`endif
        cycle();
        #1;
        check("tie_back_idle", dbg_state, ST_IDLE);
        cycle();

        // Reset during an I-side fill with 2 reads in flight.
        i_req = 1'b1; i_addr = 16'h0300;
        cycle();
        cycle();
        cycle();
        #1;
        check("rst_pre_inflight", dbg_inflight, 2);
        check("rst_pre_i_gnt", i_gnt, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_i_gnt", i_gnt, 0);
        check("rst_mid_mem_en", mem_en, 0);
        check("rst_mid_state", dbg_state, ST_IDLE);
        check("rst_mid_inflight", dbg_inflight, 0);
        i_req = 1'b0;
        #1;
        rst_n = 1'b1;
        cycle();
        for (int k = 0; k < 2; k++) begin
            mem_rvld = 1'b1;
            #1;
            check("late_i_vld", i_data_vld, 0);
            check("late_d_vld", d_data_vld, 0);
            cycle();
        end
        mem_rvld = 1'b0;
        #1;
        check("late_inflight", dbg_inflight, 0);

        // Stray return in IDLE, followed by a short grant that must release
        // promptly.
        mem_rvld = 1'b1;
        #1;
        check("stray_i_vld", i_data_vld, 0);
        check("stray_d_vld", d_data_vld, 0);
        cycle();
        mem_rvld = 1'b0;
        #1;
        check("stray_inflight", dbg_inflight, 0);
        i_req = 1'b1;
        cycle();
        i_req = 1'b0;
        #1;
        check("stray_i_own", dbg_state, ST_I_OWN);
        check("stray_no_read", mem_en, 0);
        cycle();
        #1;
        check("stray_release", dbg_state, ST_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the single shared multi-cycle main memory between the I-cache and D-cache miss handlers. Each cache fill FSM raises its busy/request line and drives its word address. The arbiter grants one client at a time, forwards that client's addresses to memory, and steers returning data-valid pulses back to the owner only. The arbiter also carries single-word write-through stores from the D-side. It sits between the two fill FSMs and the 4-cycle pipelined memory model.

## Interface
- Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MAX_INFLIGHT, 7, maximum outstanding reads tracked (counter is 3 bits)
- Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  I-cache fill FSM busy; held high for the whole block fill
- i_addr  in  ADDR_W  I-side read address
- i_gnt  out  1  I-side owns memory
- i_data_vld  out  1  mem_rvld steered to I-side
- d_req  in  1  D-side request (fill or store)
- d_wr  in  1  D-side request is a single-word write; sampled with d_req
- d_addr  in  ADDR_W  D-side address
- d_wdata  in  DATA_W  D-side store data
- d_gnt  out  1  D-side owns memory
- d_data_vld  out  1  mem_rvld steered to D-side
- rdata  out  DATA_W  mem_rdata broadcast to both caches
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvld  in  1  memory read data valid

## Operation
- States: IDLE, I_OWN, D_OWN, D_WRITE. Reset enters IDLE.
- IDLE: no grant, mem_en=0.
  - If only i_req is high, go to I_OWN.
  - If only d_req is high, go to D_WRITE when d_wr=1, else D_OWN.
  - If both are high, resolve per Configuration.
- I_OWN: i_gnt=1, mem_addr=i_addr, mem_en=i_req, mem_wr=0.
- D_OWN: same as I_OWN using the D-side signals.
- D_WRITE: lasts exactly one cycle. d_gnt=1, mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata. Always returns to IDLE.
- Inflight counter:
  - +1 on each cycle with mem_en & ~mem_wr.
  - −1 on each mem_rvld.
  - Both in the same cycle: count unchanged.
  - Saturates at MAX_INFLIGHT; never wraps below 0.
- Release: I_OWN or D_OWN returns to IDLE only when the owner's req is low AND inflight==0. Late data is never steered to the wrong client.
- i_data_vld = mem_rvld & (state==I_OWN). d_data_vld likewise for D_OWN. A mem_rvld in any other state is dropped.
- rdata = mem_rdata, combinational.
- mem_wdata = 0 outside D_WRITE.
- Reset mid-fill: state goes to IDLE, inflight=0, all grants drop immediately. Data returning afterwards is not steered.

## Timing
- Reset values: i_gnt, d_gnt, i_data_vld, d_data_vld, mem_en, mem_wr = 0. mem_addr, mem_wdata = 0.
- Grant latency: a req sampled high at edge N gives gnt high from edge N onward. The first mem_en is in cycle N+1 after the request cycle.
- All grant and memory-control outputs are decoded from registered state plus current req/addr. There is no combinational path from mem_rvld to mem_en.
- Release takes one edge after the condition (req low, inflight==0). IDLE then spends at least one cycle before the next grant.
- Memory read latency is not assumed. Only mem_rvld count matching matters.

## Configuration
- ARB_RR_EN:
  - Defined: when both requests arrive in IDLE, grant goes to the client not granted most recently. A last-owner flop resets to I, so D wins the first tie.
  - Undefined: D always wins ties. The last-owner flop is not built.

## Test plan
- i_req=1, i_addr stepping 0x0000..0x000E over 8 cycles, mem_rvld ×8 returned 4 cycles later, then i_req=0 -> i_gnt high throughout, exactly 8 i_data_vld pulses, 0 d_data_vld, return to IDLE after the 8th pulse.
- d_req=1, d_wr=1, d_addr=0x1234, d_wdata=0xBEEF -> exactly one cycle with mem_en=1, mem_wr=1, mem_addr=0x1234, mem_wdata=0xBEEF, d_gnt=1; back to IDLE the next cycle.
- i_req dropped while 3 reads are outstanding, d_req pending -> i_gnt held until the 3rd mem_rvld, then d_gnt; every pulse seen as i_data_vld.
- Both requests in the same IDLE cycle, twice in a row -> with ARB_RR_EN: D then I. Without it: D then D.
- rst_n pulsed low during I_OWN with 2 reads in flight -> i_gnt and mem_en drop asynchronously. Subsequent mem_rvld produces no i_data_vld or d_data_vld.
- mem_rvld injected in IDLE -> no data_vld output; inflight stays 0.
